// File: rtl/exc_pkg.sv
// Shared constants, state encoding and capture payload for the exception sequencer.
package exc_pkg;

  localparam int unsigned PC_W    = 30;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned IP_W    = 8;
  localparam int unsigned MAX_IRQ = 8;

  // ExcCode values written into Cause
  localparam logic [CODE_W-1:0] EXC_INT = 5'd0;
  localparam logic [CODE_W-1:0] EXC_SYS = 5'd8;
  localparam logic [CODE_W-1:0] EXC_RI  = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV  = 5'd12;

  // Status register bit positions
  localparam int unsigned ST_EXL    = 0;
  localparam int unsigned ST_IM_LSB = 8;

  // Cause register field positions
  localparam int unsigned CA_CODE_LSB = 2;
  localparam int unsigned CA_IP_LSB   = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAVE   = 2'd1,
    S_VECTOR = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  // Everything latched at accept time and replayed during SAVE
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [IP_W-1:0]   ip;
    logic [PC_W-1:0]   epc_src;
    logic              keep_epc;
  } exc_cap_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Picks the winning request: synchronous faults first (RI > OV > SYS), then
// masked interrupts, which are only taken at an instruction boundary with EXL clear.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 6
) (
  input  logic               exc_ri_i,
  input  logic               exc_ov_i,
  input  logic               exc_sys_i,
  input  logic [NUM_IRQ-1:0] irq_m_i,
  input  logic               instr_done_i,
  input  logic               exl_i,
  output logic               take_o,
  output logic [CODE_W-1:0]  code_o,
  output logic               is_int_o
);

  logic exc_any;
  logic int_ok;

  assign exc_any = exc_ri_i | exc_ov_i | exc_sys_i;
  assign int_ok  = instr_done_i & ~exl_i & (|irq_m_i);

  // Fixed-priority code selection
  always_comb begin
    code_o = EXC_INT;
    if (exc_ri_i) begin
      code_o = EXC_RI;
    end else if (exc_ov_i) begin
      code_o = EXC_OV;
    end else if (exc_sys_i) begin
      code_o = EXC_SYS;
    end
  end

  assign take_o   = exc_any | int_ok;
  assign is_int_o = ~exc_any & int_ok;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: accepts a request in IDLE, then writes
// Cause/EPC (SAVE), sets EXL and jumps to the handler (VECTOR); ERET clears
// EXL and jumps back to EPC (RETURN). Outputs are decoded from state and
// captured registers only.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned     NUM_IRQ     = 6,
  parameter logic [PC_W-1:0] VECTOR_ADDR = 30'h0000_0020
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_ri,
  input  logic               exc_ov,
  input  logic               exc_sys,
  input  logic               eret,
  input  logic               instr_done,
  input  logic [PC_W-1:0]    pc_cur,
  input  logic [PC_W-1:0]    pc_next,
  input  logic [REG_W-1:0]   status_q,
  input  logic [PC_W-1:0]    epc_q,
  output logic [PC_W-1:0]    epc_data,
  output logic               EPCWrite,
  output logic [REG_W-1:0]   cause_data,
  output logic               CWrite,
  output logic               sset,
  output logic               srst,
  output logic               flush,
  output logic               pc_redirect,
  output logic [PC_W-1:0]    pc_target,
  output logic               busy
);

  state_t   state_q, state_d;
  exc_cap_t cap_q, cap_d;

  logic [NUM_IRQ-1:0] irq_m;
  logic [IP_W-1:0]    ip_ext;
  logic               exl;
  logic               take;
  logic [CODE_W-1:0]  code;
  logic               is_int;
  logic               unused_status;

  assign exl   = status_q[ST_EXL];
  assign irq_m = irq & status_q[ST_IM_LSB +: NUM_IRQ];

  // Only EXL and the implemented IM bits are consumed
  assign unused_status = ^{status_q[REG_W-1:ST_IM_LSB+NUM_IRQ],
                           status_q[ST_IM_LSB-1:ST_EXL+1]};

  // Zero-extend masked pending lines to the 8-bit Cause.IP field
  always_comb begin
    ip_ext              = '0;
    ip_ext[NUM_IRQ-1:0] = irq_m;
  end

  exc_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .exc_ri_i     (exc_ri),
    .exc_ov_i     (exc_ov),
    .exc_sys_i    (exc_sys),
    .irq_m_i      (irq_m),
    .instr_done_i (instr_done),
    .exl_i        (exl),
    .take_o       (take),
    .code_o       (code),
    .is_int_o     (is_int)
  );

  // State and capture registers, synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state and capture logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d          = S_SAVE;
          cap_d.code       = code;
          cap_d.ip         = ip_ext;
          cap_d.epc_src    = is_int ? pc_next : pc_cur;
          cap_d.keep_epc   = is_int ? 1'b0 : exl;
        end else if (eret && instr_done) begin
          state_d = S_RETURN;
        end
      end
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode; anything not driven by the current state stays 0
  always_comb begin
    epc_data    = '0;
    EPCWrite    = 1'b0;
    cause_data  = '0;
    CWrite      = 1'b0;
    sset        = 1'b0;
    srst        = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    busy        = 1'b0;
    case (state_q)
      S_SAVE: begin
        CWrite                              = 1'b1;
        cause_data[CA_CODE_LSB +: CODE_W]   = cap_q.code;
        cause_data[CA_IP_LSB +: IP_W]       = cap_q.ip;
        EPCWrite                            = ~cap_q.keep_epc;
        epc_data                            = cap_q.epc_src;
        flush                               = 1'b1;
        busy                                = 1'b1;
      end
      S_VECTOR: begin
        sset        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = VECTOR_ADDR;
        flush       = 1'b1;
        busy        = 1'b1;
      end
      S_RETURN: begin
        srst        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc_q;
        flush       = 1'b1;
        busy        = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by random traffic, all
// checked against a queue of scheduled output cycles built from the rules.
module tb_exc_ctrl;

  localparam int unsigned NUM_IRQ = 6;
  localparam logic [29:0] VEC     = 30'h20;

  logic               Clk = 1'b0;
  logic               Reset;
  logic [NUM_IRQ-1:0] irq;
  logic               exc_ri, exc_ov, exc_sys, eret, instr_done;
  logic [29:0]        pc_cur, pc_next, epc_q;
  logic [31:0]        status_q;
  logic [29:0]        epc_data, pc_target;
  logic               EPCWrite, CWrite, sset, srst, flush, pc_redirect, busy;
  logic [31:0]        cause_data;

  always #5 Clk = ~Clk;

  exc_ctrl #(.NUM_IRQ(NUM_IRQ), .VECTOR_ADDR(VEC)) dut (
    .Clk(Clk), .Reset(Reset), .irq(irq), .exc_ri(exc_ri), .exc_ov(exc_ov),
    .exc_sys(exc_sys), .eret(eret), .instr_done(instr_done), .pc_cur(pc_cur),
    .pc_next(pc_next), .status_q(status_q), .epc_q(epc_q), .epc_data(epc_data),
    .EPCWrite(EPCWrite), .cause_data(cause_data), .CWrite(CWrite), .sset(sset),
    .srst(srst), .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .busy(busy)
  );

  // One scheduled non-idle cycle: 0 = save, 1 = vector, 2 = return
  typedef struct {
    int          kind;
    logic [31:0] cause;
    logic [29:0] epc;
    logic        epcw;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ri, input logic ov, input logic sy,
                       input logic er, input logic done, input logic [NUM_IRQ-1:0] ir,
                       input logic [31:0] st, input logic [29:0] epc,
                       input logic [29:0] pcc, input logic [29:0] pcn);
    Reset = rst; exc_ri = ri; exc_ov = ov; exc_sys = sy; eret = er;
    instr_done = done; irq = ir; status_q = st; epc_q = epc;
    pc_cur = pcc; pc_next = pcn;
  endtask

  // Reference: what the coming clock edge does to the schedule
  task automatic model_edge();
    exp_t        e;
    logic [7:0]  ip;
    logic        exc, intr;
    int          code;
    if (Reset) begin
      q.delete();
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else begin
      ip   = 8'(irq & status_q[8 +: NUM_IRQ]);
      exc  = exc_ri | exc_ov | exc_sys;
      intr = !exc && instr_done && !status_q[0] && (ip != 8'd0);
      if (exc || intr) begin
        code   = exc_ri ? 10 : exc_ov ? 12 : exc_sys ? 8 : 0;
        e.kind  = 0;
        e.cause = 32'(ip) * 32'd256 + 32'(code) * 32'd4;
        e.epc   = intr ? pc_next : pc_cur;
        e.epcw  = intr ? 1'b1 : !status_q[0];
        q.push_back(e);
        e.kind  = 1;
        q.push_back(e);
      end else if (eret && instr_done) begin
        e.kind  = 2;
        e.cause = '0;
        e.epc   = '0;
        e.epcw  = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  // Compare every output against the current head of the schedule
  task automatic check_outputs();
    int k;
    k = (q.size() != 0) ? q[0].kind : -1;
    check_eq("busy",     32'(busy),        32'(k >= 0));
    check_eq("flush",    32'(flush),       32'(k >= 0));
    check_eq("CWrite",   32'(CWrite),      32'(k == 0));
    check_eq("cause",    cause_data,       (k == 0) ? q[0].cause : 32'd0);
    check_eq("EPCWrite", 32'(EPCWrite),    32'((k == 0) && q[0].epcw));
    check_eq("epc_data", 32'(epc_data),    (k == 0) ? 32'(q[0].epc) : 32'd0);
    check_eq("sset",     32'(sset),        32'(k == 1));
    check_eq("srst",     32'(srst),        32'(k == 2));
    check_eq("redirect", 32'(pc_redirect), 32'(k == 1 || k == 2));
    check_eq("target",   32'(pc_target),
             (k == 1) ? 32'(VEC) : (k == 2) ? 32'(epc_q) : 32'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, epc_q, 30'h0, 30'h0);
  endtask

  initial begin
    epc_q = '0;
    // Reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 30'h0, 30'h0, 30'h0);
    step(); step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    idle_in(); step();

    // Overflow with EXL clear
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0, 30'h0, 30'h100, 30'h104);
    step();
    check_eq("ov_cause", cause_data, 32'h0000_0030);
    check_eq("ov_epc",   32'(epc_data), 32'h100);
    idle_in(); step();
    check_eq("ov_vec",   32'(pc_target), 32'h20);
    step();
    check_eq("ov_done",  32'(busy), 32'd0);

    // Interrupt masked, then enabled, then blocked by EXL
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, 32'h0000_0000, 30'h0, 30'h40, 30'h41);
    step();
    check_eq("irq_masked", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, 32'h0000_0400, 30'h0, 30'h40, 30'h41);
    step();
    check_eq("irq_cause", cause_data, 32'h0000_0400);
    check_eq("irq_epc",   32'(epc_data), 32'h41);
    idle_in(); step(); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, 32'h0000_0401, 30'h0, 30'h40, 30'h41);
    step();
    check_eq("irq_exl", 32'(busy), 32'd0);

    // RI + OV + ERET together: RI wins, no return
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '0, 32'h0, 30'h3FF, 30'h50, 30'h51);
    step();
    check_eq("ri_cause", cause_data, 32'h0000_0028);
    idle_in(); step();
    check_eq("ri_no_ret", 32'(srst), 32'd0);
    step();

    // ERET
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h1, 30'h3FF, 30'h60, 30'h61);
    step();
    check_eq("eret_tgt", 32'(pc_target), 32'h3FF);
    check_eq("eret_srst", 32'(srst), 32'd1);
    idle_in(); step();

    // Nested SYSCALL with EXL set keeps EPC
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h1, 30'h0, 30'h70, 30'h71);
    step();
    check_eq("nest_cause", cause_data, 32'h0000_0020);
    check_eq("nest_epcw",  32'(EPCWrite), 32'd0);
    idle_in(); step();
    check_eq("nest_sset", 32'(sset), 32'd1);
    step();

    // Reset in the middle of a sequence
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0, 30'h0, 30'h80, 30'h81);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 30'h0, 30'h0, 30'h0);
    step();
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    idle_in(); step();
    check_eq("mid_rst_sset", 32'(sset), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 0),
            NUM_IRQ'($urandom),
            {16'h0, 8'($urandom), 7'h0, 1'($urandom_range(0, 3) == 0)},
            30'($urandom), 30'($urandom), 30'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
